// File: rtl/riscv_pkg.sv
// Shared definitions for the core's instruction memory and its byte-stream program loader.
package riscv_pkg;

    localparam int         IMEM_ADDR_W = 8;
    localparam int         IMEM_WORD_W = 16;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_COUNT = 3'd1,
        LD_HI    = 3'd2,
        LD_LO    = 3'd3,
        LD_CHECK = 3'd4,
        LD_DONE  = 3'd5,
        LD_ERR   = 3'd6
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready byte stream feeding the program loader.
interface imem_loader_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/imem_loader.sv
// Assembles a framed byte stream into 16-bit big-endian words, writes them to instruction
// memory, verifies an additive checksum and holds the core in reset until a good image lands.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int         ADDR_W = IMEM_ADDR_W,
    parameter logic [7:0] HEADER = HEADER_BYTE
) (
    input  logic                   clock,
    input  logic                   reset,
    imem_loader_if.slave           rx,
    input  logic                   reload,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [IMEM_WORD_W-1:0] imem_wdata,
    output logic                   core_reset,
    output logic                   done,
    output logic                   error
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE  = LD_IDLE;
    localparam logic [2:0] S_COUNT = LD_COUNT;
    localparam logic [2:0] S_HI    = LD_HI;
    localparam logic [2:0] S_LO    = LD_LO;
    localparam logic [2:0] S_CHECK = LD_CHECK;
    localparam logic [2:0] S_DONE  = LD_DONE;
    localparam logic [2:0] S_ERR   = LD_ERR;

    // A COUNT byte of zero encodes a full-depth image.
    localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [7:0]             sum_q, sum_d;
    logic [7:0]             hi_q, hi_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [IMEM_WORD_W-1:0] wdata_q, wdata_d;
    logic                   rx_ready_int;
    logic                   xfer;

    assign rx_ready_int = (state_q != S_DONE);
    assign xfer         = rx.rx_valid && rx_ready_int;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (xfer && rx.rx_data == HEADER) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) begin
                    count_d = (rx.rx_data == 8'h00) ? FULL_CNT : CNT_W'(rx.rx_data);
                    idx_d   = '0;
                    sum_d   = 8'h00;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = rx.rx_data;
                    sum_d   = sum_q + rx.rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    sum_d   = sum_q + rx.rx_data;
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_W-1:0];
                    wdata_d = {hi_q, rx.rx_data};
                    if (idx_q == count_q - CNT_W'(1)) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = S_HI;
                    end
                end
            end
            S_CHECK: begin
                if (xfer) state_d = (rx.rx_data == sum_q) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                if (reload) state_d = S_IDLE;
            end
            S_ERR: begin
                // reload wins over a concurrent byte, which is simply dropped
                if (reload)                            state_d = S_IDLE;
                else if (xfer && rx.rx_data == HEADER) state_d = S_COUNT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Frame bookkeeping is always re-initialised in COUNT, so it needs no reset.
    always_ff @(posedge clock) begin
        count_q <= count_d;
        idx_q   <= idx_d;
        sum_q   <= sum_d;
        hi_q    <= hi_d;
    end

    assign rx.rx_ready  = rx_ready_int;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset   = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that sits directly upstream of the RISCV core's instruction memory. It receives a framed program image over a valid/ready byte interface and assembles big-endian 16-bit instruction words. It writes each word into instruction memory and verifies an 8-bit additive checksum. It holds the core in reset until a complete, valid image has been written.

## Interface
- `HEADER`, 8'hA5, frame start byte.
- `ADDR_W`, 8, instruction-memory address width; depth is 2**ADDR_W (256).
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader accepts a byte; a transfer occurs when `rx_valid && rx_ready` on a rising edge.
- `reload` in 1: one-cycle request to restart loading from DONE or ERR.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 16: write data.
- `core_reset` out 1: held high while no valid image is present; drives the core's `reset`.
- `done` out 1: image loaded and checksum matched.
- `error` out 1: checksum mismatch.

## Operation
- Frame format: `HEADER`, then COUNT (words; 0 means 2**ADDR_W), then COUNT×(HI byte, LO byte), then CKSUM.
- CKSUM is the mod-256 sum of all HI/LO bytes. HEADER and COUNT are excluded.
- State machine:
  - IDLE: bytes other than `HEADER` are discarded; `HEADER` → COUNT.
  - COUNT: latch count, clear word index and checksum accumulator → HI.
  - HI: latch high byte, add to sum → LO.
  - LO: form word {hi, byte}, add to sum, register write at index; if index == count−1 → CHECK, else index+1 → HI.
  - CHECK: if byte == sum → DONE, else → ERR.
  - DONE: `rx_ready`=0; `reload` → IDLE.
  - ERR: `rx_ready`=1; `HEADER` byte → COUNT; `reload` → IDLE.
- `rx_ready` = 1 in every state except DONE.
- Index and count registers are ADDR_W+1 bits so that COUNT=0 (256 words) works. `imem_addr` is index[ADDR_W-1:0] and never wraps within a frame.
- `core_reset` = 1 in all states except DONE. Entering IDLE via `reload` reasserts it on the next cycle.
- `reload` outside DONE/ERR is ignored.
- `reload` has priority over a simultaneous byte transfer in ERR; that byte is dropped.
- A second `HEADER` value mid-frame is data, not a restart.
- Reset mid-frame: all partial state is discarded. Words already written stay in memory; the loader does not clear them.

## Timing
- Reset values:
  - state = IDLE
  - `rx_ready` = 1
  - `imem_we` = 0
  - `imem_addr` = 0
  - `imem_wdata` = 0
  - `core_reset` = 1
  - `done` = 0
  - `error` = 0
- `imem_we`, `imem_addr` and `imem_wdata` are registered. The write strobe is high for exactly the one cycle after the LO-byte transfer edge. Address and data hold their last value afterwards.
- `done` and `error` are registered and rise on the cycle after the CKSUM transfer. `core_reset` falls on that same cycle as `done`.
- `done` and `error` stay high until `reset`, `reload`, or (for `error`) a new `HEADER` byte.
- Throughput: one byte per cycle. `rx_valid` gaps of any length stall the FSM without state loss.
- Minimum load time is 3 + 2·COUNT transfer cycles, plus 1 cycle to `done`.

## Structure
- Shared package `riscv_pkg` holds:
  - the loader state enum (IDLE, COUNT, HI, LO, CHECK, DONE, ERR);
  - `HEADER_BYTE`;
  - `IMEM_ADDR_W`;
  - `IMEM_WORD_W` = 16, also used by the core's instruction memory.
- Single module: one FSM plus datapath registers. No sub-module is warranted.
- The top level connects `imem_*` to the core's instruction-memory write port and `core_reset` to the core's `reset`.

## Test plan
- **Basic load:** bytes A5 02 01 26 10 32 69, back-to-back.
  - Writes mem[0]=0x0126 and mem[1]=0x1032, one `imem_we` pulse each.
  - `done`=1 and `core_reset`=0 one cycle after byte 69.
- **Bad checksum:** same frame with CKSUM 0x68.
  - Both words are written; `error`=1 and `done`=0; `core_reset` stays 1.
  - Then sending A5 01 00 07 07 → `done`=1 with mem[0]=0x0007.
- **Stalls and noise:** 3 junk bytes (0x00, 0xFF, 0x12), then the basic frame with random 0–5 cycle `rx_valid` gaps.
  - Junk is ignored; same writes and `done` result as the basic load.
- **Full depth:** COUNT=00 with 256 words where word i = {i, ~i}; each word contributes 0xFF, so CKSUM=0x00.
  - 256 writes with addresses 0..255 in order; `done`=1.
- **Reset mid-frame:** assert `reset` after A5 02 01 26 10.
  - All outputs return to reset values; a following full basic frame loads correctly.
- **Reload:** after `done`, pulse `reload`.
  - `core_reset`=1 and `done`=0 next cycle; `rx_ready`=1; a new frame loads and `done` returns.
